// File: rtl/aes_decrypt_ctrl.sv
// aes_decrypt_ctrl: iterative AES-128 decryption sequencer.
// Takes one ciphertext block, applies the initial AddRoundKey with the last
// round key, and then reuses one external combinational reverseround
// instance for NR inverse rounds. It fetches one round key per cycle from an
// external key store.
// Optional feature: define AES_DEC_ABORT_EN to add the 'abort' input, which
// drops an in-flight block.
module aes_decrypt_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] ct,
    output logic [3:0]   key_idx,
    input  logic [127:0] key_in,
    output logic [127:0] rr_in,
    output logic [127:0] rr_key,
    output logic         rr_last,
    input  logic [127:0] rr_out,
    output logic [127:0] pt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
`ifdef AES_DEC_ABORT_EN
    ,
    input  logic         abort
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        ROUND,
        DONE
    } state_t;

    // The last round key is used for the initial whitening step. The round
    // counter starts one below it.
    localparam logic [3:0] KEY_LAST  = 4'(NR);
    localparam logic [3:0] RND_FIRST = 4'(NR - 1);

    state_t       state;
    logic [127:0] st;
    logic [3:0]   rnd;

    // Sequencer: this block holds the state register, the round counter and the registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            st        <= '0;
            rnd       <= 4'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end
`ifdef AES_DEC_ABORT_EN
        else if (abort && (state != IDLE)) begin
            state     <= IDLE;
            rnd       <= 4'd0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end
`endif
        else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        st    <= ct;
                        busy  <= 1'b1;
                        state <= INIT;
                    end
                end
                INIT: begin
                    st    <= st ^ key_in;
                    rnd   <= RND_FIRST;
                    state <= ROUND;
                end
                ROUND: begin
                    st <= rr_out;
                    if (rnd == 4'd0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rnd <= rnd - 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    // Datapath steering: this block requests the key and feeds the shared reverseround. key_in returns in the same cycle, so the steering cannot be registered.
    always_comb begin
        key_idx = 4'd0;
        rr_in   = '0;
        rr_key  = '0;
        rr_last = 1'b0;
        case (state)
            INIT: begin
                key_idx = KEY_LAST;
            end
            ROUND: begin
                key_idx = rnd;
                rr_in   = st;
                rr_key  = key_in;
                rr_last = (rnd == 4'd0);
            end
            default: begin
            end
        endcase
    end

    // Reset has priority over a handshake, so in_ready is masked while rst is high.
    assign in_ready = (state == IDLE) && !rst;
    assign pt       = st;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// tb_aes_decrypt_ctrl: scoreboard bench for aes_decrypt_ctrl.
// The bench models the key store and the reverseround datapath. Both use the
// FIPS-197 byte order, where byte k sits at bits [127-8k -: 8].
// The controller only XORs and routes 128-bit words, so the byte order only
// has to be consistent inside the bench.
module tb_aes_decrypt_ctrl;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] ct;
    logic [3:0]   key_idx;
    logic [127:0] key_in;
    logic [127:0] rr_in;
    logic [127:0] rr_key;
    logic         rr_last;
    logic [127:0] rr_out;
    logic [127:0] pt;
    logic         out_valid;
    logic         out_ready;
    logic         busy;
`ifdef AES_DEC_ABORT_EN
    logic         abort = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0]   sbox_t  [256];
    logic [7:0]   isbox_t [256];
    logic [127:0] rk      [11];

    logic [127:0] exp_q [$];
    int           acc_q [$];

    aes_decrypt_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ct        (ct),
        .key_idx   (key_idx),
        .key_in    (key_in),
        .rr_in     (rr_in),
        .rr_key    (rr_key),
        .rr_last   (rr_last),
        .rr_out    (rr_out),
        .pt        (pt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef AES_DEC_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // Free-running clock with a period of 10 time units.
    always #5 clk = ~clk;

    // Count edges so that latencies can be measured in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    // Multiply two bytes in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Apply one inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns unless this is the last round.
    function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   a [16];
        logic [7:0]   b [16];
        logic [127:0] r;
        logic [7:0]   c0, c1, c2, c3;
        for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
        for (int row = 0; row < 4; row++)
            for (int col = 0; col < 4; col++)
                b[row + 4*col] = isbox_t[a[row + 4*((col - row + 4) % 4)]];
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
        r = r ^ k;
        if (!last) begin
            for (int col = 0; col < 4; col++) begin
                c0 = r[127-32*col -: 8];
                c1 = r[119-32*col -: 8];
                c2 = r[111-32*col -: 8];
                c3 = r[103-32*col -: 8];
                r[127-32*col -: 8] = gmul(c0,8'h0e) ^ gmul(c1,8'h0b) ^ gmul(c2,8'h0d) ^ gmul(c3,8'h09);
                r[119-32*col -: 8] = gmul(c0,8'h09) ^ gmul(c1,8'h0e) ^ gmul(c2,8'h0b) ^ gmul(c3,8'h0d);
                r[111-32*col -: 8] = gmul(c0,8'h0d) ^ gmul(c1,8'h09) ^ gmul(c2,8'h0e) ^ gmul(c3,8'h0b);
                r[103-32*col -: 8] = gmul(c0,8'h0b) ^ gmul(c1,8'h0d) ^ gmul(c2,8'h09) ^ gmul(c3,8'h0e);
            end
        end
        return r;
    endfunction

    // Model the key store and the reverseround datapath as same-cycle combinational logic.
    always_comb begin
        key_in = (key_idx <= 4'd10) ? rk[key_idx] : '0;
        rr_out = inv_round(rr_in, rr_key, rr_last);
    end

    // Compare one 128-bit value and log a failure.
    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Compare one single-bit flag.
    task automatic checkFlag(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b, required %b", name, act, exp);
        end
    endtask

    // Compare one integer count.
    task automatic checkCount(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Offer a block and wait for the accept edge. If track is set, the expected plaintext and the accept edge go to the scoreboard.
    task automatic applyStimulus(input logic [127:0] c, input logic [127:0] exp, input bit track,
                                 output int acc);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        ct       = c;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        acc = cyc + 1;
        if (n >= 200) begin
            checkFlag("accept_timeout", in_ready, 1'b1);
        end else if (track) begin
            exp_q.push_back(exp);
            acc_q.push_back(acc);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait until the scoreboard has consumed every expected block, with a time bound.
    task automatic drainScoreboard(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkCount(name, exp_q.size(), 0);
    endtask

    // Monitor: on each rise of out_valid, pop the expected plaintext and the accept edge. While out_valid stays high, check that pt holds.
    logic [127:0] held;
    bit           seen = 1'b0;
    always @(negedge clk) begin
        logic [127:0] e;
        int           a;
        if (out_valid && !seen) begin
            seen = 1'b1;
            held = pt;
            if (exp_q.size() == 0) begin
                bad++;
                total++;
                $display("[TB] FAIL unexpected_out_valid: got pt %h, required no output", pt);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                checkOutput("plaintext", pt, e);
                checkCount("latency", cyc - a, 11);
            end
        end else if (out_valid) begin
            checkOutput("pt_hold", pt, held);
        end
        if (!out_valid) seen = 1'b0;
    end

    // Watchdog: stop the run if the bench hangs.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Build the S-box tables and expand the FIPS-197 C.1 key.
    initial begin
        logic [7:0]  inv;
        logic [7:0]  s;
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                    ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[a]  = s;
            isbox_t[s] = 8'(a);
        end
        {w[0], w[1], w[2], w[3]} = C1_KEY;
        rcon = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rcon;
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end

    // Main directed sequence.
    initial begin
        int acc1;
        int acc2;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        ct        = '0;
        out_ready = 1'b1;

        // Reset values, checked while rst is still held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("key10_model", rk[10], C1_K10);
        checkFlag("rst_in_ready", in_ready, 1'b0);
        checkFlag("rst_out_valid", out_valid, 1'b0);
        checkFlag("rst_busy", busy, 1'b0);
        checkOutput("rst_pt", pt, '0);
        checkCount("rst_key_idx", int'(key_idx), 0);
        checkOutput("rst_rr_in", rr_in, '0);
        checkOutput("rst_rr_key", rr_key, '0);
        checkFlag("rst_rr_last", rr_last, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkFlag("idle_in_ready", in_ready, 1'b1);

        // FIPS-197 C.1 block, with the key index sequence and rr_last checked cycle by cycle.
        applyStimulus(C1_CT, C1_PT, 1'b1, acc1);
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            checkCount("key_idx_seq", int'(key_idx), 10 - k);
            checkFlag("rr_last_seq", rr_last, (k == 10));
            checkFlag("busy_run", busy, 1'b1);
        end
        drainScoreboard("c1_drain");

        // Backpressure: DONE holds for 20 cycles while a second block is offered.
        out_ready = 1'b0;
        applyStimulus(C1_CT, C1_PT, 1'b1, acc1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkFlag("bp_out_valid", out_valid, 1'b1);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            ct       = 128'hdeadbeef_00000000_cafef00d_12345678;
            checkFlag("bp_in_ready", in_ready, 1'b0);
            checkFlag("bp_valid_hold", out_valid, 1'b1);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkFlag("bp_release_valid", out_valid, 1'b0);
        checkFlag("bp_release_ready", in_ready, 1'b1);
        checkFlag("bp_release_busy", busy, 1'b0);
        repeat (15) @(negedge clk);
        checkFlag("bp_no_second_block", busy, 1'b0);

        // Reset in the middle of a block: no output, then a fresh block decrypts correctly.
        applyStimulus(C1_CT, C1_PT, 1'b0, acc1);
        n = 0;
        while (key_idx != 4'd5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkCount("mid_key_idx", int'(key_idx), 5);
        rst = 1'b1;
        @(negedge clk);
        checkFlag("mid_rst_busy", busy, 1'b0);
        checkFlag("mid_rst_valid", out_valid, 1'b0);
        checkCount("mid_rst_key_idx", int'(key_idx), 0);
        rst = 1'b0;
        @(negedge clk);
        checkFlag("mid_rst_ready", in_ready, 1'b1);
        repeat (15) @(negedge clk);
        applyStimulus(C1_CT, C1_PT, 1'b1, acc1);
        drainScoreboard("post_reset_drain");

        // Back-to-back blocks with out_ready tied high: the accepts are 13 cycles apart.
        applyStimulus(C1_CT, C1_PT, 1'b1, acc1);
        applyStimulus(C1_CT, C1_PT, 1'b1, acc2);
        checkCount("b2b_spacing", acc2 - acc1, 13);
        drainScoreboard("b2b_drain");

`ifdef AES_DEC_ABORT_EN
        // Abort at key index 3: the block is dropped, and the next block is unaffected.
        applyStimulus(C1_CT, C1_PT, 1'b0, acc1);
        n = 0;
        while (key_idx != 4'd3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkCount("abort_key_idx", int'(key_idx), 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkFlag("abort_busy", busy, 1'b0);
        checkFlag("abort_valid", out_valid, 1'b0);
        checkFlag("abort_ready", in_ready, 1'b1);
        repeat (15) @(negedge clk);
        applyStimulus(C1_CT, C1_PT, 1'b1, acc1);
        drainScoreboard("post_abort_drain");
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
